// File: rtl/mm_block_responder_if.sv
// Request/response bundle between a data cache (master) and the block memory responder (slave).
interface mm_block_responder_if #(
  parameter int BLOCK_BYTES = 8
);
  localparam int DATA_W = BLOCK_BYTES * 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mm_block_responder.sv
// Main-memory responder: one block read/write in flight, fixed access latency, held response.
// Optional feature macro: MM_ADDR_CHECK_EN (flag out-of-range addresses with resp_err).
module mm_block_responder #(
  parameter int BLOCK_BYTES = 8,
  parameter int NUM_BLOCKS  = 64,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mm_block_responder_if.slave   bus
);
  localparam int DATA_W = BLOCK_BYTES * 8;
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(NUM_BLOCKS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              load, access, release_resp, commit;

  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aerr_q;
  logic              addr_err;

  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  logic [DATA_W-1:0] mem_q [NUM_BLOCKS];

  // Only the index field is architecturally used; the remaining address bits are folded here.
  logic              addr_unused;
  assign addr_unused = ^bus.req_addr;

`ifdef MM_ADDR_CHECK_EN
  localparam logic [31:0] MEM_BYTES = 32'(NUM_BLOCKS * BLOCK_BYTES);
  assign addr_err = (bus.req_addr >= MEM_BYTES);
`else
  assign addr_err = 1'b0;
`endif

  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load         = 1'b0;
    access       = 1'b0;
    release_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          load    = 1'b1;
          cnt_d   = 8'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          release_resp = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        resp_rdata_q <= (wr_q || aerr_q) ? '0 : mem_q[idx_q];
        resp_err_q   <= aerr_q;
      end else if (release_resp) begin
        resp_rdata_q <= '0;
        resp_err_q   <= 1'b0;
      end
    end
  end

  // Request capture; only meaningful while BUSY, so no reset needed.
  always_ff @(posedge clk) begin
    if (load) begin
      wr_q    <= bus.req_write;
      idx_q   <= bus.req_addr[OFF_W +: IDX_W];
      wdata_q <= bus.req_wdata;
      aerr_q  <= addr_err;
    end
  end

  // Reset aborts an in-flight write before it can reach the array.
  assign commit = access && wr_q && !aerr_q && !reset;

  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[idx_q] <= wdata_q;
    end
  end
endmodule
